// File: rtl/nn_seq_tester.sv
// Exhaustive 16-vector tester for a 4-input complex gate, w = ~((c|d) & (~d | (a&b))).
// Optional build macro NN_TESTER_HALT_ON_FAIL_EN: stop at the first mismatching vector.
module nn_seq_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_w,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_vec
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // SETTLE | vector applied, waiting SETTLE_CYCLES for the gate to settle
  // SAMPLE | one cycle: compare dut_w against the golden value
  // DONE   | run finished, results held until the next start
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic       exp_w;
  logic       miss;
  logic       last_vec;

  assign a = vec[3];
  assign b = vec[2];
  assign c = vec[1];
  assign d = vec[0];

  assign exp_w = ~((vec[1] | vec[0]) & (~vec[0] | (vec[3] & vec[2])));
  assign pass  = done & (err_count == 5'd0);

  // Defaults to a miss so an X/Z on dut_w counts as an error in simulation.
  always_comb begin
    miss = 1'b1;
    if (dut_w == exp_w) miss = 1'b0;
  end

`ifdef NN_TESTER_HALT_ON_FAIL_EN
  assign last_vec = miss | (vec == 4'd15);
`else
  assign last_vec = (vec == 4'd15);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == SETTLE_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          if (miss) begin
            err_count <= err_count + 5'd1;
            if (err_count == 5'd0) fail_vec <= vec;
          end
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            vec   <= vec + 4'd1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_seq_tester.sv
// Randomized fault-mask runs of nn_seq_tester checked by a queue scoreboard.
module tb_nn_seq_tester;

  localparam int S = 4;
  localparam logic [15:0] GOLD = 16'h1BBB;  // golden ones at 0,1,3,4,5,7,8,9,11,12

  typedef struct {
    int         cyc;
    logic [4:0] err;
    logic [3:0] fv;
    logic       ps;
    logic [3:0] last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_w;
  logic       a, b, c, d, busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] fail_vec;
  logic [15:0] mask = '0;
  logic [3:0] vec_w;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       done_prev = 1'b0;
  exp_t       sb[$];

  nn_seq_tester #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_w(dut_w),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate model: golden behaviour with the bits of mask inverted.
  assign vec_w = {a, b, c, d};
  assign dut_w = GOLD[vec_w] ^ mask[vec_w];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [15:0] m, input int acc);
    exp_t e;
    int n = 0;
    int first = -1;
    for (int i = 0; i < 16; i++)
      if (m[i]) begin
        n++;
        if (first < 0) first = i;
      end
`ifdef NN_TESTER_HALT_ON_FAIL_EN
    if (n > 0) begin
      e.cyc = acc + (first + 1) * (S + 1);
      e.err = 5'd1;
      e.fv = 4'(first);
      e.ps = 1'b0;
      e.last = 4'(first);
      return e;
    end
`endif
    e.cyc = acc + 16 * (S + 1);
    e.err = 5'(n);
    e.fv = (first < 0) ? 4'd0 : 4'(first);
    e.ps = (n == 0);
    e.last = 4'd15;
    return e;
  endfunction

  // Monitor: a rising done pops one expectation.
  always @(negedge clk) begin
    if (!rst && done && !done_prev) begin
      chk("sb_pending", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err_count", err_count, e.err);
        if (e.err != 0) chk("fail_vec", fail_vec, e.fv);
        chk("pass", pass, e.ps);
        chk("held_vec", vec_w, e.last);
        chk("busy_in_done", busy, 0);
      end
    end
    done_prev = done;
  end

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic run(input logic [15:0] m, input bit poke);
    exp_t e;
    int len;
    mask = m;
    start = 1'b1;
    e = model(m, cyc + 1);
    sb.push_back(e);
    len = e.cyc - (cyc + 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_drops", done, 0);
    if (poke) begin
      repeat ($urandom_range(1, len - 2)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_abcd"}, vec_w, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fv"}, fail_vec, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    run(16'h0000, 1'b0);
    run(~GOLD, 1'b0);
    run(GOLD, 1'b1);
    for (int k = 0; k < 6; k++) begin
      logic [15:0] m;
      m = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run(m, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a run at vector 7.
    mask = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && vec_w != 4'd7; i++) @(negedge clk);
    chk("reach_vec7", vec_w, 7);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    run(16'h0000, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
